gl_raster_dispatch: RTL and testbench

Triangle dispatcher and sequencer for `gl_rasterizer`. It accepts a stream of vertices over a valid/ready handshake and assembles them into triangles. It presents each triangle to the rasterizer's three vertex inputs with a one-cycle start strobe, then holds the next triangle off until the rasterizer signals completion. It sits between the vertex FIFO/transform stage and `gl_rasterizer`, and owns the rasterizer's start/done protocol, the completion timeout and triangle accounting.

---
 rtl/gl_raster_pkg.sv | 23 ++
 rtl/gl_vertex_slots.sv | 44 ++++
 rtl/gl_raster_dispatch.sv | 175 +++++++++++++++++
 tb/tb_gl_raster_dispatch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gl_raster_pkg.sv
// Shared definitions for the raster dispatch slice: vertex word layout,
// dispatch FSM states and the default completion timeout.
package gl_raster_pkg;

  localparam int VERTEX_TYPE_SIZE = 96;

  // IEEE-754 single-precision x/y fields inside a vertex word
  localparam int VTX_X_MSB = 95;
  localparam int VTX_X_LSB = 64;
  localparam int VTX_Y_MSB = 63;
  localparam int VTX_Y_LSB = 32;

  // Completion timeout; the WAIT counter is 20 bits wide
  localparam int TIMEOUT_CYCLES_DEFAULT = 1048575;
  localparam int TMO_W                  = 20;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2
  } dispatch_state_e;

endpackage

// File: rtl/gl_vertex_slots.sv
// Three-entry vertex register file: write at the current fill index,
// shift down by one (strip reuse), or clear. Clear wins over shift,
// shift wins over write.
module gl_vertex_slots
  import gl_raster_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [1:0]                  wr_idx,
  input  logic [VERTEX_TYPE_SIZE-1:0] wr_data,
  input  logic                        shift,
  input  logic                        clear,
  output logic [VERTEX_TYPE_SIZE-1:0] slot0,
  output logic [VERTEX_TYPE_SIZE-1:0] slot1
);

  logic [VERTEX_TYPE_SIZE-1:0] slot_q [3];

  // Slot storage: clear / shift / indexed write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      slot_q[2] <= '0;
    end else if (clear) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      slot_q[2] <= '0;
    end else if (shift) begin
      slot_q[0] <= slot_q[1];
      slot_q[1] <= slot_q[2];
      slot_q[2] <= '0;
    end else if (wr_en && (wr_idx < 2'd3)) begin
      slot_q[wr_idx] <= wr_data;
    end
  end

  // The third vertex is forwarded straight from the input by the parent,
  // so only the two oldest slots are visible outside.
  assign slot0 = slot_q[0];
  assign slot1 = slot_q[1];

endmodule

// File: rtl/gl_raster_dispatch.sv
// Triangle dispatcher for gl_rasterizer: assembles vertices into
// triangles, issues a one-cycle start strobe, waits for the rising edge
// of the rasterizer's done signal (or a timeout) and counts completions.
// Optional build macro GL_RASTER_STRIP_EN enables triangle-strip mode
// (slot shift on completion, winding-preserving parity swap).
module gl_raster_dispatch
  import gl_raster_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vtx_valid,
  input  logic [VERTEX_TYPE_SIZE-1:0] vtx_data,
  input  logic                        vtx_last,
  output logic                        vtx_ready,
  output logic                        rast_start,
  output logic [VERTEX_TYPE_SIZE-1:0] rast_v1,
  output logic [VERTEX_TYPE_SIZE-1:0] rast_v2,
  output logic [VERTEX_TYPE_SIZE-1:0] rast_v3,
  input  logic                        rast_done,
  output logic                        busy,
  output logic [15:0]                 tri_count,
  output logic                        timeout_err
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  dispatch_state_e             state_q, state_d;
  logic [1:0]                  cnt_q;
  logic                        run_q;
  logic                        done_prev_q;
  logic [TMO_W-1:0]            tmo_cnt_q;

  logic                        accept, complete, discard;
  logic                        done_edge, wait_done, wait_tmo, wait_exit;
  logic                        keep_strip;
  logic                        slot_shift, slot_clear;
  logic [VERTEX_TYPE_SIZE-1:0] slot0, slot1;

  assign accept    = vtx_valid & vtx_ready;
  assign complete  = accept & (cnt_q == 2'd2);
  assign discard   = accept & vtx_last & (cnt_q < 2'd2);
  assign done_edge = rast_done & ~done_prev_q;
  assign wait_done = (state_q == ST_WAIT) & done_edge;
  // A done edge in the same cycle as the limit still counts as completion
  assign wait_tmo  = (state_q == ST_WAIT) & ~done_edge & (tmo_cnt_q == TMO_LAST);
  assign wait_exit = wait_done | wait_tmo;

  // run_q keeps vtx_ready low while reset is asserted and releases it one
  // cycle after reset deassertion.
  assign vtx_ready = run_q & (state_q == ST_COLLECT) & (cnt_q != 2'd3);

`ifdef GL_RASTER_STRIP_EN
  logic last_q;
  logic parity_q;

  // A strip continues only after a real completion of a non-final triangle
  assign keep_strip = wait_done & ~last_q;

  // Strip bookkeeping: vtx_last of the issued triangle and winding parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (complete) begin
      last_q   <= vtx_last;
      parity_q <= ~parity_q;
    end else if (wait_exit && !keep_strip) begin
      parity_q <= 1'b0;
    end
  end
`else
  assign keep_strip = 1'b0;
`endif

  assign slot_shift = keep_strip;
  assign slot_clear = discard | (wait_exit & ~keep_strip);

  gl_vertex_slots u_slots (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_idx  (cnt_q),
    .wr_data (vtx_data),
    .shift   (slot_shift),
    .clear   (slot_clear),
    .slot0   (slot0),
    .slot1   (slot1)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_COLLECT;
    else        state_q <= state_d;
  end

  // FSM next state and strobe/busy outputs
  always_comb begin
    state_d    = state_q;
    rast_start = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      ST_COLLECT: if (complete) state_d = ST_ISSUE;
      ST_ISSUE: begin
        rast_start = 1'b1;
        busy       = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (wait_exit) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Slot fill count: discard, accept, or post-WAIT reload (2 when a strip continues)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_q <= 2'd0;
    else if (discard)   cnt_q <= 2'd0;
    else if (accept)    cnt_q <= cnt_q + 2'd1;
    else if (wait_exit) cnt_q <= keep_strip ? 2'd2 : 2'd0;
  end

  // Rasterizer vertex outputs, loaded as the triangle completes in COLLECT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rast_v1 <= '0;
      rast_v2 <= '0;
      rast_v3 <= '0;
    end else if (complete) begin
`ifdef GL_RASTER_STRIP_EN
      if (parity_q) begin
        rast_v1 <= slot1;
        rast_v2 <= slot0;
      end else begin
        rast_v1 <= slot0;
        rast_v2 <= slot1;
      end
`else
      rast_v1 <= slot0;
      rast_v2 <= slot1;
`endif
      rast_v3 <= vtx_data;
    end
  end

  // Done edge history, WAIT timeout counter and run enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_prev_q <= 1'b0;
      tmo_cnt_q   <= '0;
      run_q       <= 1'b0;
    end else begin
      done_prev_q <= rast_done;
      run_q       <= 1'b1;
      if (state_q == ST_ISSUE)     tmo_cnt_q <= '0;
      else if (state_q == ST_WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Completion counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_count   <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      if (wait_done) tri_count   <= tri_count + 16'd1;
      if (wait_tmo)  timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gl_raster_dispatch.sv
// Directed bench for gl_raster_dispatch (TIMEOUT_CYCLES = 16).
module tb_gl_raster_dispatch;
  import gl_raster_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        vtx_valid = 1'b0;
  logic [VERTEX_TYPE_SIZE-1:0] vtx_data = '0;
  logic                        vtx_last = 1'b0;
  logic                        vtx_ready;
  logic                        rast_start;
  logic [VERTEX_TYPE_SIZE-1:0] rast_v1, rast_v2, rast_v3;
  logic                        rast_done = 1'b0;
  logic                        busy;
  logic [15:0]                 tri_count;
  logic                        timeout_err;

  int total = 0;
  int bad   = 0;

  // x = 1.0 .. 8.0, y = distinct tags
  localparam logic [95:0] VA = {32'h3F800000, 32'h000000A1, 32'h0};
  localparam logic [95:0] VB = {32'h40000000, 32'h000000B2, 32'h0};
  localparam logic [95:0] VC = {32'h40400000, 32'h000000C3, 32'h0};
  localparam logic [95:0] VD = {32'h40800000, 32'h000000D4, 32'h0};
  localparam logic [95:0] VE = {32'h40A00000, 32'h000000E5, 32'h0};
  localparam logic [95:0] VF = {32'h40C00000, 32'h000000F6, 32'h0};
  localparam logic [95:0] VG = {32'h40E00000, 32'h00000017, 32'h0};
  localparam logic [95:0] VH = {32'h41000000, 32'h00000028, 32'h0};

  gl_raster_dispatch #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vtx_valid   (vtx_valid),
    .vtx_data    (vtx_data),
    .vtx_last    (vtx_last),
    .vtx_ready   (vtx_ready),
    .rast_start  (rast_start),
    .rast_v1     (rast_v1),
    .rast_v2     (rast_v2),
    .rast_v3     (rast_v3),
    .rast_done   (rast_done),
    .busy        (busy),
    .tri_count   (tri_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one vertex; returns one cycle after it is accepted
  task automatic push(input logic [95:0] v, input logic last);
    int n = 0;
    vtx_valid = 1'b1;
    vtx_data  = v;
    vtx_last  = last;
    while (!vtx_ready && n < 50) begin
      step();
      n++;
    end
    total++;
    if (!vtx_ready) begin
      bad++;
      $display("FAIL push_ready: vtx_ready=%b after %0d cycles, want 1", vtx_ready, n);
    end
    step();
    vtx_valid = 1'b0;
    vtx_last  = 1'b0;
  endtask

  // From the ISSUE cycle: move to WAIT and deliver one done pulse
  task automatic finish_tri();
    step();
    rast_done = 1'b1;
    step();
    rast_done = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (rast_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", rast_start); end
    total++; if (tri_count !== 16'd0) begin bad++; $display("FAIL rst_tri_count: got %0d want 0", tri_count); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    total++; if (vtx_ready !== 1'b0) begin bad++; $display("FAIL rst_vtx_ready: got %b want 0", vtx_ready); end
    total++; if (rast_v1 !== 96'd0) begin bad++; $display("FAIL rst_v1: got %h want 0", rast_v1); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (vtx_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", vtx_ready); end
  endtask

  task automatic test_list();
    push(VA, 1'b0);
    total++; if (rast_start !== 1'b0) begin bad++; $display("FAIL list_early_start: got %b want 0", rast_start); end
    push(VB, 1'b0);
    push(VC, 1'b0);
    total++; if (rast_start !== 1'b1) begin bad++; $display("FAIL list_start: got %b want 1", rast_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL list_busy: got %b want 1", busy); end
    total++; if (vtx_ready !== 1'b0) begin bad++; $display("FAIL list_ready_issue: got %b want 0", vtx_ready); end
    total++; if (rast_v1 !== VA) begin bad++; $display("FAIL list_v1: got %h want %h", rast_v1, VA); end
    total++; if (rast_v2 !== VB) begin bad++; $display("FAIL list_v2: got %h want %h", rast_v2, VB); end
    total++; if (rast_v3 !== VC) begin bad++; $display("FAIL list_v3: got %h want %h", rast_v3, VC); end
    step();
    total++; if (rast_start !== 1'b0) begin bad++; $display("FAIL list_start_one_cycle: got %b want 0", rast_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL list_busy_wait: got %b want 1", busy); end
    total++; if (rast_v1 !== VA) begin bad++; $display("FAIL list_v1_stable: got %h want %h", rast_v1, VA); end
    rast_done = 1'b1;
    step();
    rast_done = 1'b0;
    total++; if (tri_count !== 16'd1) begin bad++; $display("FAIL list_tri_count: got %0d want 1", tri_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL list_busy_done: got %b want 0", busy); end
    total++; if (vtx_ready !== 1'b1) begin bad++; $display("FAIL list_ready_done: got %b want 1", vtx_ready); end
  endtask

  task automatic test_discard();
    push(VA, 1'b0);
    push(VB, 1'b1);
    total++; if (rast_start !== 1'b0) begin bad++; $display("FAIL discard_start: got %b want 0", rast_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL discard_busy: got %b want 0", busy); end
    push(VC, 1'b0);
    total++; if (rast_start !== 1'b0) begin bad++; $display("FAIL discard_count_reset: got %b want 0", rast_start); end
    push(VD, 1'b0);
    push(VE, 1'b1);
    total++; if (rast_start !== 1'b1) begin bad++; $display("FAIL discard_next_start: got %b want 1", rast_start); end
    total++; if (rast_v1 !== VC) begin bad++; $display("FAIL discard_v1: got %h want %h", rast_v1, VC); end
    total++; if (rast_v2 !== VD) begin bad++; $display("FAIL discard_v2: got %h want %h", rast_v2, VD); end
    total++; if (rast_v3 !== VE) begin bad++; $display("FAIL discard_v3: got %h want %h", rast_v3, VE); end
    finish_tri();
    total++; if (tri_count !== 16'd2) begin bad++; $display("FAIL discard_tri_count: got %0d want 2", tri_count); end
  endtask

  task automatic test_level_done();
    push(VF, 1'b0);
    push(VG, 1'b0);
    push(VH, 1'b0);
    step();
    rast_done = 1'b1;
    step();
    total++; if (tri_count !== 16'd3) begin bad++; $display("FAIL level_first: got %0d want 3", tri_count); end
    push(VA, 1'b0);
    push(VB, 1'b0);
    push(VC, 1'b0);
    total++; if (rast_start !== 1'b1) begin bad++; $display("FAIL level_start: got %b want 1", rast_start); end
    for (int i = 0; i < 4; i++) step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL level_held_busy: got %b want 1", busy); end
    total++; if (tri_count !== 16'd3) begin bad++; $display("FAIL level_held_count: got %0d want 3", tri_count); end
    rast_done = 1'b0;
    step();
    rast_done = 1'b1;
    step();
    rast_done = 1'b0;
    total++; if (tri_count !== 16'd4) begin bad++; $display("FAIL level_edge_count: got %0d want 4", tri_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL level_edge_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    push(VD, 1'b0);
    push(VE, 1'b0);
    push(VF, 1'b0);
    step();                               // WAIT cycle 1
    for (int i = 0; i < 15; i++) step();  // WAIT cycle 16
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL tmo_busy_16: got %b want 1", busy); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
    step();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", timeout_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy: got %b want 0", busy); end
    total++; if (vtx_ready !== 1'b1) begin bad++; $display("FAIL tmo_ready: got %b want 1", vtx_ready); end
    total++; if (tri_count !== 16'd4) begin bad++; $display("FAIL tmo_tri_count: got %0d want 4", tri_count); end
    push(VA, 1'b0);
    push(VB, 1'b0);
    push(VC, 1'b0);
    total++; if (rast_v1 !== VA) begin bad++; $display("FAIL tmo_next_v1: got %h want %h", rast_v1, VA); end
    finish_tri();
    total++; if (tri_count !== 16'd5) begin bad++; $display("FAIL tmo_next_count: got %0d want 5", tri_count); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
  endtask

`ifdef GL_RASTER_STRIP_EN
  task automatic test_strip();
    push(VA, 1'b0);
    push(VB, 1'b0);
    push(VC, 1'b0);
    total++; if ({rast_v1, rast_v2, rast_v3} !== {VA, VB, VC}) begin bad++; $display("FAIL strip_t1: got %h %h %h", rast_v1, rast_v2, rast_v3); end
    finish_tri();
    total++; if (vtx_ready !== 1'b1) begin bad++; $display("FAIL strip_ready: got %b want 1", vtx_ready); end
    push(VD, 1'b0);
    total++; if (rast_start !== 1'b1) begin bad++; $display("FAIL strip_t2_start: got %b want 1", rast_start); end
    total++; if ({rast_v1, rast_v2, rast_v3} !== {VC, VB, VD}) begin bad++; $display("FAIL strip_t2: got %h %h %h", rast_v1, rast_v2, rast_v3); end
    finish_tri();
    push(VE, 1'b1);
    total++; if ({rast_v1, rast_v2, rast_v3} !== {VC, VD, VE}) begin bad++; $display("FAIL strip_t3: got %h %h %h", rast_v1, rast_v2, rast_v3); end
    finish_tri();
    push(VF, 1'b0);
    push(VG, 1'b0);
    total++; if (rast_start !== 1'b0) begin bad++; $display("FAIL strip_end_count: got %b want 0", rast_start); end
    push(VH, 1'b0);
    total++; if ({rast_v1, rast_v2, rast_v3} !== {VF, VG, VH}) begin bad++; $display("FAIL strip_new: got %h %h %h", rast_v1, rast_v2, rast_v3); end
    finish_tri();
  endtask
`endif

  task automatic test_reset_mid_wait();
    push(VB, 1'b0);
    push(VC, 1'b0);
    push(VD, 1'b0);
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (rast_start !== 1'b0) begin bad++; $display("FAIL mid_start: got %b want 0", rast_start); end
    total++; if (tri_count !== 16'd0) begin bad++; $display("FAIL mid_tri_count: got %0d want 0", tri_count); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL mid_timeout_err: got %b want 0", timeout_err); end
    step();
    rst_n = 1'b1;
    step();
    step();
    total++; if (vtx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", vtx_ready); end
    total++; if (tri_count !== 16'd0) begin bad++; $display("FAIL mid_no_count: got %0d want 0", tri_count); end
  endtask

  initial begin
    test_reset();
    test_list();
    test_discard();
    test_level_done();
    test_timeout();
`ifdef GL_RASTER_STRIP_EN
    test_strip();
`endif
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
